// File: rtl/vr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vr_pkg
//  Description : Shared types and constants for the valid/ready pipe slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package vr_pkg;

    // Upper bound on the number of cascaded slice stages.
    localparam int VR_MAX_DEPTH = 16;

    // Per-stage register style.
    typedef enum logic [1:0] {
        VR_MODE_FULL   = 2'd0,   // main + skid, registered ready
        VR_MODE_FWD    = 2'd1,   // main only, combinational ready
        VR_MODE_BYPASS = 2'd2    // plain wires
    } vr_mode_e;

    // Occupancy state of a FULL stage.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } vr_state_e;

endpackage
`default_nettype wire

// File: rtl/vr_slice_stage.sv
`default_nettype none
// ============================================================================
//  Module      : vr_slice_stage
//  Description : One valid/ready register slice; FULL, FWD or BYPASS style.
//                Reports how many beats it currently holds (0..2).
//  Revision    : 1.0 - initial release
// ============================================================================
module vr_slice_stage
    import vr_pkg::*;
#(
    parameter int       WIDTH = 32,
    parameter vr_mode_e MODE  = VR_MODE_FULL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             up_valid_in,
    output logic             up_ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic             dn_valid_out,
    input  logic             dn_ready_in,
    output logic [1:0]       count
);

    generate
        if (MODE == VR_MODE_FULL) begin : g_full
            vr_state_e        r_state;
            vr_state_e        w_state_nxt;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic [WIDTH-1:0] w_main_nxt;
            logic [WIDTH-1:0] w_skid_nxt;
            logic             r_ready;
            logic             w_in_fire;
            logic             w_out_fire;

            assign w_in_fire  = up_valid_in & r_ready;
            assign w_out_fire = (r_state != ST_EMPTY) & dn_ready_in;

            // Next state and register contents; vacated registers are zeroed.
            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_main;
                w_skid_nxt  = r_skid;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_in_fire) begin
                            w_state_nxt = ST_ONE;
                            w_main_nxt  = data_in;
                        end
                    end
                    ST_ONE: begin
                        if (w_in_fire && !w_out_fire) begin
                            w_state_nxt = ST_TWO;
                            w_skid_nxt  = data_in;
                        end else if (!w_in_fire && w_out_fire) begin
                            w_state_nxt = ST_EMPTY;
                            w_main_nxt  = '0;
                        end else if (w_in_fire && w_out_fire) begin
                            w_main_nxt  = data_in;
                        end
                    end
                    ST_TWO: begin
                        // Ready is low here, so only the output side can move.
                        if (w_out_fire) begin
                            w_state_nxt = ST_ONE;
                            w_main_nxt  = r_skid;
                            w_skid_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_EMPTY;
                        w_main_nxt  = '0;
                        w_skid_nxt  = '0;
                    end
                endcase
            end

            // State/data registers; ready is registered from the next state so
            // it never depends combinationally on dn_ready_in.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_EMPTY;
                    r_main  <= '0;
                    r_skid  <= '0;
                    r_ready <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_main  <= w_main_nxt;
                    r_skid  <= w_skid_nxt;
                    r_ready <= (w_state_nxt != ST_TWO);
                end
            end

            assign up_ready_out = r_ready;
            assign dn_valid_out = (r_state != ST_EMPTY);
            assign data_out     = r_main;
            assign count        = (r_state == ST_TWO) ? 2'd2 :
                                  (r_state == ST_ONE) ? 2'd1 : 2'd0;
        end else if (MODE == VR_MODE_FWD) begin : g_fwd
            logic             r_valid;
            logic [WIDTH-1:0] r_main;
            logic             w_ready;

            assign w_ready = !r_valid | dn_ready_in;

            // Single register: load on accept, clear when drained.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_main  <= '0;
                end else if (up_valid_in && w_ready) begin
                    r_valid <= 1'b1;
                    r_main  <= data_in;
                end else if (r_valid && dn_ready_in) begin
                    r_valid <= 1'b0;
                    r_main  <= '0;
                end
            end

            assign up_ready_out = w_ready;
            assign dn_valid_out = r_valid;
            assign data_out     = r_main;
            assign count        = {1'b0, r_valid};
        end else begin : g_bypass
            logic w_unused_clk_rst;

            assign w_unused_clk_rst = clk ^ rst_n;
            assign up_ready_out     = dn_ready_in;
            assign dn_valid_out     = up_valid_in;
            assign data_out         = data_in;
            assign count            = 2'd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vr_pipe_slice.sv
`default_nettype none
// ============================================================================
//  Module      : vr_pipe_slice
//  Description : DEPTH cascaded valid/ready slice stages with a running count
//                of beats held inside the block.
//  Revision    : 1.0 - initial release
// ============================================================================
module vr_pipe_slice
    import vr_pkg::*;
#(
    parameter int       WIDTH = 32,
    parameter int       DEPTH = 2,
    parameter vr_mode_e MODE  = VR_MODE_FULL
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           up_valid_in,
    output logic                           up_ready_out,
    output logic [WIDTH-1:0]               data_out,
    output logic                           dn_valid_out,
    input  logic                           dn_ready_in,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(2*DEPTH+1);

    // Each stage owns its link signals so the valid and ready chains stay
    // separate nets rather than bits of one shared vector.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            logic [WIDTH-1:0] w_din;
            logic [WIDTH-1:0] w_dout;
            logic             w_vin;
            logic             w_vout;
            logic             w_rin;
            logic             w_rdn;
            logic [1:0]       w_cnt;
            logic [OCC_W-1:0] w_acc;

            if (g == 0) begin : g_head
                assign w_din = data_in;
                assign w_vin = up_valid_in;
                assign w_acc = OCC_W'(w_cnt);
            end else begin : g_link
                assign w_din = g_stage[g-1].w_dout;
                assign w_vin = g_stage[g-1].w_vout;
                assign w_acc = g_stage[g-1].w_acc + OCC_W'(w_cnt);
            end

            if (g == DEPTH-1) begin : g_tail
                assign w_rdn = dn_ready_in;
            end else begin : g_mid
                assign w_rdn = g_stage[g+1].w_rin;
            end

            vr_slice_stage #(
                .WIDTH (WIDTH),
                .MODE  (MODE)
            ) u_stage (
                .clk          (clk),
                .rst_n        (rst_n),
                .data_in      (w_din),
                .up_valid_in  (w_vin),
                .up_ready_out (w_rin),
                .data_out     (w_dout),
                .dn_valid_out (w_vout),
                .dn_ready_in  (w_rdn),
                .count        (w_cnt)
            );
        end
    endgenerate

    assign up_ready_out = g_stage[0].w_rin;
    assign data_out     = g_stage[DEPTH-1].w_dout;
    assign dn_valid_out = g_stage[DEPTH-1].w_vout;
    assign occupancy    = g_stage[DEPTH-1].w_acc;

endmodule
`default_nettype wire
